// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: latches execute results and MEM/WB controls, resolves
// taken branches into a one-cycle pcSrc pulse and bubbles the wrong-path instruction.
module ex_mem_latch #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            validIn,
    input  logic [31:0]     outAlu,
    input  logic            zeroAlu,
    input  logic [31:0]     outAddEx,
    input  logic [31:0]     readRt,
    input  logic [4:0]      writeReg,
    input  logic            regWrite,
    input  logic            memToReg,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic            branch,
    output logic [31:0]     aluResultM,
    output logic [31:0]     branchTargetM,
    output logic [31:0]     storeDataM,
    output logic [4:0]      writeRegM,
    output logic            regWriteM,
    output logic            memToRegM,
    output logic            memReadM,
    output logic            memWriteM,
    output logic            validM,
    output logic            pcSrc,
    output logic            squash,
    output logic [CNTW-1:0] takenCount,
    output logic [CNTW-1:0] bubbleCount
);

    typedef enum logic {RUN, KILL} state_t;

    state_t          state_q, state_d;
    logic [31:0]     alu_q, alu_d;
    logic [31:0]     target_q, target_d;
    logic [31:0]     store_q, store_d;
    logic [4:0]      wreg_q, wreg_d;
    logic            regwrite_q, regwrite_d;
    logic            memtoreg_q, memtoreg_d;
    logic            memread_q, memread_d;
    logic            memwrite_q, memwrite_d;
    logic            branch_q, branch_d;
    logic            zero_q, zero_d;
    logic            valid_q, valid_d;
    logic            redirect_done_q, redirect_done_d;
    logic [CNTW-1:0] taken_q, taken_d;
    logic [CNTW-1:0] bubble_q, bubble_d;
    logic            pc_src;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    assign pc_src = valid_q & branch_q & zero_q & ~redirect_done_q;

    always_comb begin
        state_d         = state_q;
        alu_d           = alu_q;
        target_d        = target_q;
        store_d         = store_q;
        wreg_d          = wreg_q;
        regwrite_d      = regwrite_q;
        memtoreg_d      = memtoreg_q;
        memread_d       = memread_q;
        memwrite_d      = memwrite_q;
        branch_d        = branch_q;
        zero_d          = zero_q;
        valid_d         = valid_q;
        redirect_done_d = redirect_done_q;
        taken_d         = taken_q;
        bubble_d        = bubble_q;

        // A pending kill is either this cycle's redirect or one deferred by a stall.
        if (flush || (!stall && (pc_src || state_q == KILL))) begin
            valid_d         = 1'b0;
            regwrite_d      = 1'b0;
            memtoreg_d      = 1'b0;
            memread_d       = 1'b0;
            memwrite_d      = 1'b0;
            branch_d        = 1'b0;
            redirect_done_d = 1'b0;
            bubble_d        = sat_inc(bubble_q);
            state_d         = RUN;
        end else if (stall) begin
            if (pc_src) begin
                redirect_done_d = 1'b1;
                state_d         = KILL;
            end
        end else begin
            alu_d           = outAlu;
            target_d        = outAddEx;
            store_d         = readRt;
            wreg_d          = writeReg;
            zero_d          = zeroAlu;
            valid_d         = validIn;
            regwrite_d      = regWrite & validIn;
            memtoreg_d      = memToReg & validIn;
            memread_d       = memRead  & validIn;
            memwrite_d      = memWrite & validIn;
            branch_d        = branch   & validIn;
            redirect_done_d = 1'b0;
        end

        // Each redirect is counted once, on the edge that ends its pcSrc cycle.
        if (pc_src) begin
            taken_d = sat_inc(taken_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RUN;
            alu_q           <= '0;
            target_q        <= '0;
            store_q         <= '0;
            wreg_q          <= '0;
            regwrite_q      <= 1'b0;
            memtoreg_q      <= 1'b0;
            memread_q       <= 1'b0;
            memwrite_q      <= 1'b0;
            branch_q        <= 1'b0;
            zero_q          <= 1'b0;
            valid_q         <= 1'b0;
            redirect_done_q <= 1'b0;
            taken_q         <= '0;
            bubble_q        <= '0;
        end else begin
            state_q         <= state_d;
            alu_q           <= alu_d;
            target_q        <= target_d;
            store_q         <= store_d;
            wreg_q          <= wreg_d;
            regwrite_q      <= regwrite_d;
            memtoreg_q      <= memtoreg_d;
            memread_q       <= memread_d;
            memwrite_q      <= memwrite_d;
            branch_q        <= branch_d;
            zero_q          <= zero_d;
            valid_q         <= valid_d;
            redirect_done_q <= redirect_done_d;
            taken_q         <= taken_d;
            bubble_q        <= bubble_d;
        end
    end

    assign aluResultM    = alu_q;
    assign branchTargetM = target_q;
    assign storeDataM    = store_q;
    assign writeRegM     = wreg_q;
    assign regWriteM     = regwrite_q;
    assign memToRegM     = memtoreg_q;
    assign memReadM      = memread_q;
    assign memWriteM     = memwrite_q;
    assign validM        = valid_q;
    assign pcSrc         = pc_src;
    assign squash        = pc_src;
    assign takenCount    = taken_q;
    assign bubbleCount   = bubble_q;

endmodule
